// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: restoring shift-subtract 16-bit unsigned divider, one quotient bit per cycle
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       gg,
  output logic       pg
);
  logic [3:0] g, p, c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign s = p ^ c;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg = &p;
endmodule

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic [3:0] gg, pg, gc;
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (pg[0] & cin);
  assign gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
  assign gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & cin);
  assign cout = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0]) | (&pg & cin);
  for (genvar k = 0; k < 4; k++) begin : g_blk
    cla4 u_cla4 (
      .a   (a[4*k +: 4]),
      .b   (b[4*k +: 4]),
      .cin (gc[k]),
      .s   (s[4*k +: 4]),
      .gg  (gg[k]),
      .pg  (pg[k])
    );
  end
endmodule

module seq_divider_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [15:0] r, q, dvs, sum, r_nxt, q_nxt;
  logic [16:0] r_sh;
  logic cout, borrow, zero, to_done;
  cla16 u_cla (
    .a    (r_sh[15:0]),
    .b    (~dvs),
    .cin  (1'b1),
    .s    (sum),
    .cout (cout)
  );
  always_comb begin
    r_sh = {r, q[15]};
    borrow = r_sh[16] ^ ~cout;
    r_nxt = borrow ? r_sh[15:0] : sum;
    q_nxt = {q[14:0], ~borrow};
    zero = dvs == 16'd0;
    state_nxt = state == IDLE ? (start ? RUN : IDLE)
              : state == RUN  ? ((zero || cnt == 4'd15) ? DONE : RUN)
              : IDLE;
    to_done = state == RUN && state_nxt == DONE;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      r <= 16'd0;
      q <= 16'd0;
      dvs <= 16'd0;
      quotient <= 16'd0;
      remainder <= 16'd0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        dvs <= divisor;
        q <= dividend;
        r <= 16'd0;
        cnt <= 4'd0;
        div_by_zero <= 1'b0;
      end else if (state == RUN && !zero) begin
        r <= r_nxt;
        q <= q_nxt;
        cnt <= cnt + 4'd1;
      end
      if (to_done) begin
        quotient <= zero ? 16'hFFFF : q_nxt;
        remainder <= zero ? q : r_nxt;
        div_by_zero <= zero;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider_16bit.sv
// tb_seq_divider_16bit: scoreboard bench for seq_divider_16bit
module tb_seq_divider_16bit;
  logic clk, rst, start, busy, done, div_by_zero;
  logic [15:0] dividend, divisor, quotient, remainder;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;
  exp_t sb[$];
  seq_divider_16bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void push(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    e.q = b == 16'd0 ? 16'hFFFF : a / b;
    e.r = b == 16'd0 ? a : a % b;
    e.z = b == 16'd0;
    sb.push_back(e);
  endfunction
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      check("pending_on_done", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.z));
        if (e.b != 16'd0) begin
          check("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
          check("rem_lt_div", 32'(remainder < e.b), 1);
        end
      end
    end
  end
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, output int lat, output int bsy);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    push(a, b);
    lat = 0;
    bsy = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      bsy += int'(busy);
    end while (!done && lat < 40);
    check("done_seen", 32'(done), 1);
    @(negedge clk);
  endtask
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 1);
  endtask
  initial begin
    int lat, bsy;
    logic [15:0] a, b;
    rst = 1'b1;
    start = 1'b1;
    dividend = 16'd77;
    divisor = 16'd3;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_quotient", 32'(quotient), 0);
    check("rst_remainder", 32'(remainder), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    start = 1'b0;
    rst = 1'b0;
    run_div(16'd100, 16'd7, lat, bsy);
    check("basic_latency", 32'(lat), 17);
    check("basic_busy_cycles", 32'(bsy), 17);
    check("basic_done_pulse", 32'(done), 0);
    check("basic_idle", 32'(busy), 0);
    run_div(16'hFFFF, 16'd1, lat, bsy);
    run_div(16'h8000, 16'hFFFF, lat, bsy);
    run_div(16'd3, 16'd10, lat, bsy);
    run_div(16'd5, 16'd0, lat, bsy);
    check("dz_latency", 32'(lat), 2);
    check("dz_held", 32'(div_by_zero), 1);
    run_div(16'd9, 16'd3, lat, bsy);
    check("dz_cleared", 32'(div_by_zero), 0);
    @(negedge clk);
    dividend = 16'd40;
    divisor = 16'd6;
    start = 1'b1;
    push(16'd40, 16'd6);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 16'd50;
    divisor = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("abuse_done");
    check("abuse_quotient", 32'(quotient), 6);
    repeat (25) @(negedge clk);
    check("abuse_ignored", 32'(busy), 0);
    dividend = 16'd12;
    divisor = 16'd4;
    start = 1'b1;
    push(16'd12, 16'd4);
    @(negedge clk);
    wait_done("hold_done1");
    dividend = 16'd20;
    divisor = 16'd3;
    push(16'd20, 16'd3);
    @(negedge clk);
    check("hold_idle_gap", 32'(busy), 0);
    @(negedge clk);
    check("hold_retrigger", 32'(busy), 1);
    start = 1'b0;
    wait_done("hold_done2");
    @(negedge clk);
    dividend = 16'd500;
    divisor = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_quotient", 32'(quotient), 0);
    check("abort_remainder", 32'(remainder), 0);
    check("abort_dbz", 32'(div_by_zero), 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_stays_idle", 32'(busy), 0);
    run_div(16'd1000, 16'd33, lat, bsy);
    check("post_abort_quotient", 32'(quotient), 30);
    check("post_abort_remainder", 32'(remainder), 10);
    for (int i = 0; i < 1500; i++) begin
      a = 16'($urandom);
      b = i % 50 == 0 ? 16'd0 : $urandom_range(0, 2) == 0 ? 16'($urandom_range(1, 255)) : 16'($urandom);
      run_div(a, b, lat, bsy);
      check("rand_latency", 32'(lat), b == 16'd0 ? 2 : 17);
    end
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
